// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned WORD_BYTES       = 4;

  typedef enum logic {
    WAIT,
    HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: synchronous FIFO of fetch_entry with a registered head.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  fetch_entry wdata,
  output logic       full,
  output logic       empty,
  output logic       head_valid,
  output fetch_entry head
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_next;
  logic [AW:0]     occ_after_pop;
  logic [AW-1:0]   rd_next;
  logic            pop_ok;
  logic            push_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    pop_ok        = pop & ~empty;
    push_ok       = push & (~full | pop_ok);
    rd_next       = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
    occ_after_pop = pop_ok ? count - 1'b1 : count;
    count_next    = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear && push_ok) mem[wr_ptr] <= wdata;
  end

  // Head is a register copy of the next oldest entry; when the buffer runs
  // dry the incoming word bypasses storage, and otherwise the head holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      count <= count_next;
      if (occ_after_pop != '0) begin
        head       <= mem[rd_next];
        head_valid <= 1'b1;
      end else if (push_ok) begin
        head       <= wdata;
        head_valid <= 1'b1;
      end else begin
        head_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, waits MEM_LATENCY cycles per word, buffers words for decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned BUF_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  fetch_state_e state;
  logic [3:0]   cnt;
  logic         fetch_due;
  logic         push;
  logic         pop;
  logic         buf_full;
  logic         buf_empty;
  fetch_entry   wdata;
  fetch_entry   head;

  // Redirect suppresses both push and pop so nothing survives the flush.
  always_comb begin
    fetch_due = (state == HOLD) || (cnt == CNT_LAST);
    pop       = if_ready & ~buf_empty & ~redirect_valid;
    push      = fetch_due & ~redirect_valid & (~buf_full | pop);
    wdata     = '{pc: PC, instr: instruction};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC    <= RESET_PC;
      cnt   <= '0;
      state <= WAIT;
    end else if (redirect_valid) begin
      PC    <= redirect_pc & ~32'h3;
      cnt   <= '0;
      state <= WAIT;
    end else begin
      unique case (state)
        WAIT: begin
          if (cnt == CNT_LAST) begin
            if (push) begin
              PC  <= PC + 32'(WORD_BYTES);
              cnt <= '0;
            end else begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          if (push) begin
            PC    <= PC + 32'(WORD_BYTES);
            cnt   <= '0;
            state <= WAIT;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .clear      (redirect_valid),
    .wdata      (wdata),
    .full       (buf_full),
    .empty      (buf_empty),
    .head_valid (if_valid),
    .head       (head)
  );

  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Requester side of the instruction-memory interface. Owns the program counter, drives PC to the combinational instruction memory and waits a fixed number of cycles for the word to settle.
- Captures each fetched word, with its PC, into a small in-order buffer. Presents buffered words to decode through a valid/ready handshake.
- Sits between the instruction memory and the decode stage. Accepts branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- MEM_LATENCY, 2, clock cycles PC must be held stable before instruction is sampled. Legal range 1..15.
- BUF_DEPTH, 2, entries in the fetch buffer. Power of two, minimum 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- PC  out  32  fetch address to instruction memory; byte address, bits [1:0] always 0.
- instruction  in  32  word returned by instruction memory for the current PC.
- redirect_valid  in  1  one-cycle pulse: discard in-flight and buffered fetches, restart at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- if_valid  out  1  fetch buffer head holds a valid word.
- if_ready  in  1  decode accepts the head this cycle.
- if_instr  out  32  instruction word at buffer head.
- if_pc  out  32  PC of the word at buffer head.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - PC=RESET_PC, wait counter=0, state=WAIT.
  - Buffer empty, if_valid=0, if_instr=0, if_pc=0.
- FSM states:
  - WAIT: counts cycles with PC held. At the edge where counter==MEM_LATENCY-1:
    - if there is space (count<BUF_DEPTH, or a pop occurs this cycle): push {PC, instruction}, PC<=PC+4, counter<=0, stay in WAIT;
    - otherwise: go to HOLD, keeping PC.
  - HOLD: PC stable, word already valid. Push on the first edge with space, then PC<=PC+4, counter<=0, go to WAIT.
- Throughput is one word per MEM_LATENCY cycles while decode keeps up. First if_valid rises MEM_LATENCY edges after reset release.
- Pop: on an edge with if_valid=1 and if_ready=1. Push and pop in the same cycle are legal at any occupancy, including full.
- PC arithmetic: 32-bit unsigned. 32'hFFFFFFFC+4 wraps to 0, no flag.
- Redirect (redirect_valid=1 on an edge) overrides all other events that cycle:
  - buffer cleared, if_valid=0 next cycle;
  - PC<=redirect_pc & ~3, counter<=0, state<=WAIT;
  - any push or pop in the same cycle is suppressed;
  - decode discards a head consumed coincident with a redirect.
- Outputs if_valid, if_instr and if_pc are registered (buffer head). No combinational path from instruction or if_ready to any output.
- if_instr and if_pc hold their last value when if_valid=0.
- Reset asserted mid-fetch: immediate return to reset values; no partial push.

Decomposition:
- Shared package `fetch_pkg`: RESET_PC default, word size (4), the FSM state encoding {WAIT, HOLD}, and a `fetch_entry` struct {pc[31:0], instr[31:0]}.
- One natural sub-module, `fetch_buffer`: a synchronous FIFO of fetch_entry with push, pop, clear, full and empty. The top level holds the PC, counter and FSM.

Test Plan:
- Reset then free run (bench memory words 0..3 = 8c010004, 8c02000c, 8c030014, 8c04001c; if_ready=1; MEM_LATENCY=2) -> if_valid pulses every 2 cycles with (if_pc, if_instr) = (0,8c010004), (4,8c02000c), (8,8c030014), (C,8c04001c).
- Backpressure (if_ready=0 for 10 cycles) -> buffer fills with PC 0 and 4. PC holds at 8 in HOLD, no further push. On if_ready=1, words drain in order with no loss or duplicate; fetch resumes at 8.
- Redirect while buffer holds 2 entries (redirect_pc=32'h2B) -> if_valid=0 next cycle. PC=0x28; next delivered word is mem[10] with if_pc=0x28.
- Redirect coincident with push and pop -> buffer empty after the edge; neither the old-path word nor PC+4 appears.
- Wrap: redirect_pc=FFFFFFFC -> word tagged FFFFFFFC delivered, then PC=0 and word 0 delivered.
- Async reset asserted mid-WAIT (counter=1) -> outputs reset with no clock edge. After release, first word is (0,8c010004) after MEM_LATENCY edges.
